// File: rtl/turbo_pkg.sv
// Shared turbo decoder definitions: iteration controller state encoding,
// SISO order select values and default iteration bounds.
package turbo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START1 = 3'd1,
      ST_RUN1   = 3'd2,
      ST_START2 = 3'd3,
      ST_RUN2   = 3'd4,
      ST_CHECK  = 3'd5,
      ST_FINISH = 3'd6
   } iter_state_e;

   localparam logic SEL_NAT = 1'b0;
   localparam logic SEL_ILV = 1'b1;

   localparam int DEF_MAX_ITER = 16;
   localparam int DEF_MIN_ITER = 2;
   localparam int DEF_ITER_W   = 5;

   // A request of 0 selects the full budget; anything larger is clamped to it.
   function automatic int clamp_limit(input int req, input int max_iter);
      if (req == 0 || req > max_iter) begin
         return max_iter;
      end
      return req;
   endfunction

endpackage

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: drives one SISO engine through DEC1
// (natural order) / DEC2 (interleaved order) half-iterations until limit or convergence.
module turbo_iter_ctrl
   import turbo_pkg::*;
#(
   parameter int MAX_ITER = DEF_MAX_ITER,
   parameter int MIN_ITER = DEF_MIN_ITER,
   parameter int ITER_W   = DEF_ITER_W
) (
   input  logic              clk_p_i,
   input  logic              reset_n_i,
   input  logic              start_i,
   input  logic [ITER_W-1:0] max_iter_i,
   input  logic              early_en_i,
   input  logic              abort_i,
   input  logic              siso_done_i,
   input  logic              hd_equal_i,
   output logic              siso_start_o,
   output logic              siso_sel_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ITER_W-1:0] iter_cnt_o,
   output logic              early_stop_o
);

   // Handshake: start_i is a request accepted only while idle (busy_o=0);
   // siso_start_o launches one half-iteration and siso_done_i is honoured only
   // while waiting for it; done_o pulses once per block that was not aborted.

   localparam logic [ITER_W-1:0] MIN_L = ITER_W'(MIN_ITER);

   iter_state_e       state_q;
   iter_state_e       state_d;
   logic [ITER_W-1:0] limit_r;
   logic              early_en_r;
   logic              conv_r;

   logic              start_acc;
   logic              half2_done;
   logic              early_hit;
   logic              limit_hit;
   logic [ITER_W-1:0] limit_in;

   assign limit_in  = ITER_W'(clamp_limit(int'(max_iter_i), MAX_ITER));
   assign early_hit = early_en_r && conv_r && (iter_cnt_o >= MIN_L);
   assign limit_hit = (iter_cnt_o == limit_r);

   always_comb begin
      state_d    = state_q;
      start_acc  = 1'b0;
      half2_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_START1;
               start_acc = 1'b1;
            end
         end
         ST_START1: state_d = ST_RUN1;
         ST_RUN1: begin
            if (siso_done_i) begin
               state_d = ST_START2;
            end
         end
         ST_START2: state_d = ST_RUN2;
         ST_RUN2: begin
            if (siso_done_i) begin
               state_d    = ST_CHECK;
               half2_done = 1'b1;
            end
         end
         ST_CHECK: begin
            if (early_hit || limit_hit) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_START1;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // Abort overrides every transition, including a start in the same cycle.
      if (abort_i) begin
         state_d    = ST_IDLE;
         start_acc  = 1'b0;
         half2_done = 1'b0;
      end
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= ST_IDLE;
         limit_r      <= '0;
         early_en_r   <= 1'b0;
         conv_r       <= 1'b0;
         siso_start_o <= 1'b0;
         siso_sel_o   <= SEL_NAT;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         iter_cnt_o   <= '0;
         early_stop_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         // Outputs follow the state being entered so they align with it.
         siso_start_o <= (state_d == ST_START1) || (state_d == ST_START2);
         busy_o       <= (state_d != ST_IDLE);
         done_o       <= (state_d == ST_FINISH);
         if (state_d == ST_START1) begin
            siso_sel_o <= SEL_NAT;
         end else if (state_d == ST_START2) begin
            siso_sel_o <= SEL_ILV;
         end
         if (start_acc) begin
            limit_r      <= limit_in;
            early_en_r   <= early_en_i;
            conv_r       <= 1'b0;
            iter_cnt_o   <= '0;
            early_stop_o <= 1'b0;
         end
         if (half2_done) begin
            iter_cnt_o <= iter_cnt_o + 1'b1;
            conv_r     <= hd_equal_i;
         end
         if (state_q == ST_CHECK && early_hit && !abort_i) begin
            early_stop_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Directed bench for turbo_iter_ctrl: SISO responder, per-cycle busy model,
// block-level expected start-order queue and hand-computed result pins.
module tb_turbo_iter_ctrl;
   import turbo_pkg::*;

   localparam int W        = DEF_ITER_W;
   localparam int SISO_DLY = 10;

   logic         clk_p_i    = 1'b0;
   logic         reset_n_i  = 1'b0;
   logic         start_i    = 1'b0;
   logic [W-1:0] max_iter_i = '0;
   logic         early_en_i = 1'b0;
   logic         abort_i    = 1'b0;
   logic         hd_equal_i = 1'b0;
   logic         resp_done  = 1'b0;
   logic         spur_done  = 1'b0;
   logic         siso_done_i;
   logic         siso_start_o;
   logic         siso_sel_o;
   logic         busy_o;
   logic         done_o;
   logic [W-1:0] iter_cnt_o;
   logic         early_stop_o;

   assign siso_done_i = resp_done | spur_done;

   turbo_iter_ctrl dut (
      .clk_p_i      (clk_p_i),
      .reset_n_i    (reset_n_i),
      .start_i      (start_i),
      .max_iter_i   (max_iter_i),
      .early_en_i   (early_en_i),
      .abort_i      (abort_i),
      .siso_done_i  (siso_done_i),
      .hd_equal_i   (hd_equal_i),
      .siso_start_o (siso_start_o),
      .siso_sel_o   (siso_sel_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .iter_cnt_o   (iter_cnt_o),
      .early_stop_o (early_stop_o)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk_p_i = ~clk_p_i;

   int cyc = 0;
   always @(posedge clk_p_i) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- SISO responder ----------------
   bit hd_cfg       = 1'b0;
   int last_ilv_cyc = 0;
   logic cur_sel;

   always begin
      @(negedge clk_p_i);
      if (siso_start_o === 1'b1) begin
         cur_sel = siso_sel_o;
         repeat (SISO_DLY) @(posedge clk_p_i);
         #1;
         resp_done  = 1'b1;
         hd_equal_i = hd_cfg;
         if (cur_sel) last_ilv_cyc = cyc;
         @(posedge clk_p_i);
         #1;
         resp_done  = 1'b0;
         hd_equal_i = 1'b0;
      end
   end

   // ---------------- busy model + per-cycle compare ----------------
   bit   exp_busy = 1'b0;
   logic obs_q[$];
   int   done_cnt  = 0;
   int   start_cyc = 0;

   always @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i)                 exp_busy <= 1'b0;
      else if (abort_i)               exp_busy <= 1'b0;
      else if (!exp_busy && start_i)  exp_busy <= 1'b1;
      else if (done_o)                exp_busy <= 1'b0;
   end

   always @(negedge clk_p_i) begin
      if (reset_n_i) begin
         check("busy", busy_o, exp_busy);
         if (siso_start_o) begin
            if (obs_q.size() == 0) check("start_lat", cyc - start_cyc, 1);
            obs_q.push_back(siso_sel_o);
         end
         if (done_o) begin
            done_cnt++;
            check("done_lat", cyc - last_ilv_cyc, 2);
         end
      end
   end

   // ---------------- driver / block scoreboard ----------------
   task automatic issue_start(input int mi, input bit ee);
      @(posedge clk_p_i);
      #1;
      start_i    = 1'b1;
      max_iter_i = W'(mi);
      early_en_i = ee;
      start_cyc  = cyc;
   endtask

   task automatic run_block(input int mi, input bit ee, input bit hd,
                            input bit spur, input bit mid_start);
      int   lim;
      int   n;
      bit   exp_es;
      logic exp_q[$];
      bit   fired;
      fired  = 1'b0;
      lim    = (mi == 0 || mi > DEF_MAX_ITER) ? DEF_MAX_ITER : mi;
      n      = (ee && hd) ? ((lim < DEF_MIN_ITER) ? lim : DEF_MIN_ITER) : lim;
      exp_es = ee && hd && (DEF_MIN_ITER <= lim);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(SEL_NAT);
         exp_q.push_back(SEL_ILV);
      end
      obs_q.delete();
      done_cnt = 0;
      hd_cfg   = hd;
      issue_start(mi, ee);
      @(posedge clk_p_i);
      #1;
      start_i    = 1'b0;
      max_iter_i = W'($urandom_range(0, 31));
      early_en_i = ~ee;
      spur_done  = spur;
      check("clr_iter", iter_cnt_o, 0);
      check("clr_early", early_stop_o, 0);
      @(posedge clk_p_i);
      #1;
      spur_done = 1'b0;
      for (int i = 0; i < 1500 && done_cnt == 0; i++) begin
         @(negedge clk_p_i);
         if (mid_start && !fired && obs_q.size() == 2) begin
            fired = 1'b1;
            @(posedge clk_p_i);
            #1 start_i = 1'b1;
            @(posedge clk_p_i);
            #1 start_i = 1'b0;
         end
      end
      if (done_cnt == 0) check("timeout", 0, 1);
      repeat (3) @(negedge clk_p_i);
      check("done_cnt", done_cnt, 1);
      check("iter_cnt", iter_cnt_o, n);
      check("early_stop", early_stop_o, exp_es);
      check("idle_busy", busy_o, 0);
      check("n_starts", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check("sel_seq", obs_q[i], exp_q[i]);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"}, siso_start_o, 0);
      check({tag, "_sel"},   siso_sel_o,   0);
      check({tag, "_busy"},  busy_o,       0);
      check({tag, "_done"},  done_o,       0);
      check({tag, "_iter"},  iter_cnt_o,   0);
      check({tag, "_early"}, early_stop_o, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_p_i);
      check_all_zero("rst");
      #2 reset_n_i = 1'b1;

      // Limit 3, no early stop.
      run_block(3, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_iter", iter_cnt_o, 3);
      check("t1_early", early_stop_o, 0);
      check("t1_starts", obs_q.size(), 6);

      // Convergence after MIN_ITER.
      run_block(8, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t2_iter", iter_cnt_o, 2);
      check("t2_early", early_stop_o, 1);
      check("t2_starts", obs_q.size(), 4);

      // Zero and oversized limits fall back to 16.
      run_block(0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t3_iter0", iter_cnt_o, 16);
      run_block(31, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t3_iter31", iter_cnt_o, 16);

      // Limit below MIN_ITER: limit wins, not convergence.
      run_block(1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t7_iter", iter_cnt_o, 1);
      check("t7_early", early_stop_o, 0);

      // Abort during RUN1 of iteration 2.
      obs_q.delete();
      done_cnt = 0;
      hd_cfg   = 1'b0;
      issue_start(5, 1'b0);
      @(posedge clk_p_i);
      #1 start_i = 1'b0;
      for (int i = 0; i < 200 && obs_q.size() < 3; i++) @(negedge clk_p_i);
      check("abort_reach", obs_q.size(), 3);
      @(posedge clk_p_i);
      #1 abort_i = 1'b1;
      @(posedge clk_p_i);
      #1 abort_i = 1'b0;
      @(negedge clk_p_i);
      check("abort_busy", busy_o, 0);
      check("abort_iter", iter_cnt_o, 1);
      repeat (20) @(negedge clk_p_i);
      check("abort_nodone", done_cnt, 0);
      check("abort_nostart", obs_q.size(), 3);
      check("abort_keep", iter_cnt_o, 1);
      run_block(2, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t4_iter", iter_cnt_o, 2);

      // Start during RUN2 and spurious done during START1 are ignored.
      run_block(2, 1'b0, 1'b0, 1'b1, 1'b1);
      check("t5_iter", iter_cnt_o, 2);
      check("t5_starts", obs_q.size(), 4);

      // Asynchronous reset mid-RUN2.
      obs_q.delete();
      done_cnt = 0;
      hd_cfg   = 1'b1;
      issue_start(4, 1'b0);
      @(posedge clk_p_i);
      #1 start_i = 1'b0;
      for (int i = 0; i < 200 && obs_q.size() < 2; i++) @(negedge clk_p_i);
      repeat (4) @(posedge clk_p_i);
      #3 reset_n_i = 1'b0;
      #1;
      check_all_zero("arst");
      repeat (20) @(negedge clk_p_i);
      #2 reset_n_i = 1'b1;
      run_block(1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t6_iter", iter_cnt_o, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/turbo_iter_ctrl.md
Name: turbo_iter_ctrl

Overview:
Parametrised iteration controller for the turbo decoder. It sequences one shared SISO engine through alternating half-iterations: DEC1 in natural order, then DEC2 in interleaved order. The iteration limit is set per block at run time, and early termination on hard-decision convergence is optional. It sits between the frame-level start logic and the SISO/interleaver datapath, and reports completion, the iteration count and the stop reason.

Parameters:
MAX_ITER, 16, upper bound on full iterations; also the default limit when max_iter_i is 0.
MIN_ITER, 2, minimum full iterations before early stop is allowed (1..MAX_ITER).
ITER_W, 5, width of iteration fields; must satisfy 2^ITER_W > MAX_ITER.

Ports:
clk_p_i        in   1       clock, rising edge
reset_n_i      in   1       asynchronous active-low reset
start_i        in   1       1-cycle request to start decoding a block; honoured only in IDLE
max_iter_i     in   ITER_W  iteration limit, sampled with start_i; 0 means MAX_ITER; values above MAX_ITER are clamped to MAX_ITER
early_en_i     in   1       enables early stop; sampled with start_i
abort_i        in   1       synchronous abort, any state
siso_done_i    in   1       1-cycle pulse from SISO when a half-iteration completes
hd_equal_i     in   1       hard decisions unchanged since the previous iteration; qualified by siso_done_i during RUN2
siso_start_o   out  1       1-cycle SISO start pulse
siso_sel_o     out  1       0 = DEC1/natural order, 1 = DEC2/interleaved order
busy_o         out  1       high whenever state is not IDLE
done_o         out  1       1-cycle completion pulse
iter_cnt_o     out  ITER_W  completed full iterations
early_stop_o   out  1       last block ended by convergence rather than by the limit

Behaviour:
- Reset is asynchronous on reset_n_i low. Reset values: state IDLE, every output 0, latched limit 0, latched early-enable 0.
- All outputs are registered and are decoded from the state and counters only, with no combinational input-to-output path.
- States: IDLE, START1, RUN1, START2, RUN2, CHECK, FINISH.
- IDLE: start_i=1 does the following on the same edge:
  - latches limit_r (0 becomes MAX_ITER; values above MAX_ITER are clamped);
  - latches early_en_i;
  - clears iter_cnt_o and early_stop_o;
  - moves to START1.
- START1: siso_start_o=1 and siso_sel_o=0 for exactly this cycle, then RUN1 unconditionally.
- RUN1: siso_sel_o=0; on siso_done_i move to START2.
- START2: siso_start_o=1 and siso_sel_o=1 for one cycle, then RUN2.
- RUN2: siso_sel_o=1. On siso_done_i:
  - iter_cnt_o increments;
  - conv_r <= hd_equal_i;
  - move to CHECK.
- CHECK:
  - if early_en_r, conv_r and iter_cnt_o >= MIN_ITER: set early_stop_o=1 and go to FINISH;
  - else if iter_cnt_o == limit_r: go to FINISH;
  - else go to START1.
  - If both conditions hold, early_stop_o=1.
- FINISH: done_o=1 for this cycle only, then IDLE. iter_cnt_o and early_stop_o hold their values until the next accepted start.
- siso_sel_o holds its last value in CHECK, FINISH and IDLE.
- siso_done_i in any state other than RUN1 or RUN2 is ignored, including a done in the same cycle as siso_start_o.
- hd_equal_i is ignored outside the RUN2 done cycle.
- start_i while busy_o=1 is ignored. Parameters in flight do not change.
- abort_i has priority over every transition. The next state is IDLE, with no done_o and no further siso_start_o. iter_cnt_o keeps the partial count.
- abort_i and start_i together in IDLE: abort wins and the block stays in IDLE.
- Timing, start accepted at edge 0:
  - siso_start_o high in cycle 1;
  - minimum per-iteration overhead is 3 cycles (START1, START2, CHECK) plus SISO time;
  - done_o is high 2 cycles after the final RUN2 siso_done_i.
- iter_cnt_o never exceeds MAX_ITER, so no wrap-around is possible.
- Reset mid-operation returns the block to the reset values immediately. A SISO cycle in flight is the datapath's responsibility.

Decomposition:
- Shared package turbo_pkg holds:
  - the state enum (3-bit encoding in the listed order);
  - the SISO select constants SEL_NAT=0 and SEL_ILV=1;
  - the default MAX_ITER and MIN_ITER constants, reused by decoder top and testbench.
- No sub-module. The iteration counter and limit compare are small enough to stay inline, and the whole block is about 200 lines.

Test Plan:
- max_iter_i=3, early_en_i=0, SISO done 10 cycles after each start:
  - required: exactly 6 siso_start_o pulses, with siso_sel_o sequence 0,1,0,1,0,1;
  - required: done_o once, iter_cnt_o=3, early_stop_o=0.
- max_iter_i=8, early_en_i=1, hd_equal_i=1 on every RUN2 done, MIN_ITER=2 -> stop after iteration 2: iter_cnt_o=2, early_stop_o=1, 4 start pulses.
- max_iter_i=0 -> runs 16 iterations, iter_cnt_o=16. Repeat with max_iter_i=31 -> clamped, iter_cnt_o=16.
- abort_i during RUN1 of iteration 2 -> IDLE next cycle, busy_o=0, no done_o, iter_cnt_o=1. A following start_i begins a fresh block with iter_cnt_o=0.
- start_i pulsed during RUN2, plus a spurious siso_done_i during START1:
  - both ignored;
  - sequence and final count unchanged (max_iter_i=2 gives iter_cnt_o=2).
- reset_n_i low mid-RUN2 -> all outputs 0 asynchronously. After release, start_i with max_iter_i=1 -> done_o after one iteration, iter_cnt_o=1.
